// File: rtl/io_pkg.sv
// Shared definitions for the IO port pin-side stage.
// Holds the default port width, debounce counter width and synchroniser depth,
// plus the word type used for one IO port.
package io_pkg;

  localparam int IO_WIDTH    = 16;
  localparam int DEB_BITS    = 8;
  localparam int SYNC_STAGES = 2;

  typedef logic [IO_WIDTH-1:0] io_word_t;

endpackage

// File: rtl/io_debounce_bit.sv
// One bit of the pin input filter: synchroniser chain, debounce counter,
// commit of the debounced level and the sticky rising-edge flag.
// Ports:
//   theClock  in   system clock
//   theReset  in   asynchronous active-low reset
//   pin       in   raw asynchronous pin level
//   deb_len   in   debounce length in cycles (0 behaves as 1)
//   clear     in   one-cycle pulse clearing the edge flag
//   data      out  debounced level
//   flag      out  sticky flag for debounced 0->1 commits
module io_debounce_bit
  import io_pkg::*;
#(
  parameter int DEB_BITS    = io_pkg::DEB_BITS,
  parameter int SYNC_STAGES = io_pkg::SYNC_STAGES
) (
  input  logic                theClock,
  input  logic                theReset,
  input  logic                pin,
  input  logic [DEB_BITS-1:0] deb_len,
  input  logic                clear,
  output logic                data,
  output logic                flag
);

  localparam logic [DEB_BITS:0] ONE = 1;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [DEB_BITS-1:0]    cnt_p1;
  logic                   sync_bit;
  logic [DEB_BITS:0]      cnt_inc;
  logic                   commit;

  assign sync_bit = sync_p0[SYNC_STAGES-1];
  // One extra bit so cnt+1 never wraps before the >= compare.
  assign cnt_inc  = {1'b0, cnt_p1} + ONE;
  // deb_len == 0 makes the compare always true, i.e. behaves as deb_len == 1.
  assign commit   = (sync_bit != data) && (cnt_inc >= {1'b0, deb_len});

  // Stage p0: synchroniser chain
  always_ff @(posedge theClock or negedge theReset) begin
    if (!theReset) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pin};
    end
  end

  // Stage p1: debounce counter, commit and sticky edge flag
  always_ff @(posedge theClock or negedge theReset) begin
    if (!theReset) begin
      cnt_p1 <= '0;
      data   <= 1'b0;
      flag   <= 1'b0;
    end else begin
      if (sync_bit == data) begin
        cnt_p1 <= '0;
      end else if (commit) begin
        cnt_p1 <= '0;
        data   <= sync_bit;
      end else begin
        cnt_p1 <= cnt_inc[DEB_BITS-1:0];
      end
      // Set has priority so an edge landing on a clear pulse is not lost.
      if (commit && sync_bit) begin
        flag <= 1'b1;
      end else if (clear) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/io_port_filter.sv
// Pin-side stage for one IO port between the FPGA pins and the SPI register file.
// Registers the output data/enable words onto the pad tristate controls and
// filters the pin inputs into a debounced data word with sticky rising-edge flags.
// Ports:
//   theClock    in   system clock
//   theReset    in   asynchronous active-low reset
//   pin_in      in   raw pin levels
//   deb_len     in   debounce length in cycles; 0 = bypass
//   data_out    in   output levels from the register file
//   enable_out  in   per-bit output enable; 1 = drive
//   edge_clear  in   per-bit pulse clearing the edge flag
//   pin_out     out  registered data_out to pad data
//   pin_oe      out  registered enable_out to pad enable
//   data_in     out  debounced input word
//   edge_flags  out  sticky debounced 0->1 flags
module io_port_filter
  import io_pkg::*;
#(
  parameter int WIDTH       = IO_WIDTH,
  parameter int DEB_BITS    = io_pkg::DEB_BITS,
  parameter int SYNC_STAGES = io_pkg::SYNC_STAGES
) (
  input  logic                theClock,
  input  logic                theReset,
  input  logic [WIDTH-1:0]    pin_in,
  input  logic [DEB_BITS-1:0] deb_len,
  input  logic [WIDTH-1:0]    data_out,
  input  logic [WIDTH-1:0]    enable_out,
  input  logic [WIDTH-1:0]    edge_clear,
  output logic [WIDTH-1:0]    pin_out,
  output logic [WIDTH-1:0]    pin_oe,
  output logic [WIDTH-1:0]    data_in,
  output logic [WIDTH-1:0]    edge_flags
);

  // Stage p0: output registers to the pad tristate controls
  always_ff @(posedge theClock or negedge theReset) begin
    if (!theReset) begin
      pin_out <= '0;
      pin_oe  <= '0;
    end else begin
      pin_out <= data_out;
      pin_oe  <= enable_out;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    io_debounce_bit #(
      .DEB_BITS    (DEB_BITS),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_bit (
      .theClock (theClock),
      .theReset (theReset),
      .pin      (pin_in[i]),
      .deb_len  (deb_len),
      .clear    (edge_clear[i]),
      .data     (data_in[i]),
      .flag     (edge_flags[i])
    );
  end

endmodule

// File: tb/tb_io_port_filter.sv
module tb_io_port_filter;

  logic        theClock = 1'b0;
  logic        theReset;
  logic [15:0] pin_in;
  logic [7:0]  deb_len;
  logic [15:0] data_out;
  logic [15:0] enable_out;
  logic [15:0] edge_clear;
  logic [15:0] pin_out;
  logic [15:0] pin_oe;
  logic [15:0] data_in;
  logic [15:0] edge_flags;

  int checks = 0;
  int errors = 0;
  logic v [0:23];

  io_port_filter dut (
    .theClock   (theClock),
    .theReset   (theReset),
    .pin_in     (pin_in),
    .deb_len    (deb_len),
    .data_out   (data_out),
    .enable_out (enable_out),
    .edge_clear (edge_clear),
    .pin_out    (pin_out),
    .pin_oe     (pin_oe),
    .data_in    (data_in),
    .edge_flags (edge_flags)
  );

  always #5 theClock = ~theClock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge theClock);
    #1;
  endtask

  initial begin
    theReset   = 1'b0;
    pin_in     = 16'hFFFF;
    deb_len    = 8'd8;
    data_out   = 16'hFFFF;
    enable_out = 16'h0000;
    edge_clear = 16'h0000;

    // Reset
    step(3);
    chk("rst_pin_out", pin_out, 16'h0000);
    chk("rst_pin_oe", pin_oe, 16'h0000);
    chk("rst_data_in", data_in, 16'h0000);
    chk("rst_edge_flags", edge_flags, 16'h0000);
    pin_in   = 16'h0000;
    theReset = 1'b1;
    step(1);
    chk("rel_pin_out", pin_out, 16'hFFFF);

    // Output path
    data_out   = 16'hA5A5;
    enable_out = 16'h0F0F;
    step(1);
    chk("out_pin_out", pin_out, 16'hA5A5);
    chk("out_pin_oe", pin_oe, 16'h0F0F);
    step(4);

    // Clean step, deb_len=8
    pin_in[3] = 1'b1;
    step(9);
    chk("step_early", data_in[3], 1'b0);
    step(1);
    chk("step_data", data_in[3], 1'b1);
    chk("step_flag", edge_flags[3], 1'b1);

    // Lone clear, then a 1->0 commit leaves the flag alone
    edge_clear = 16'h0008;
    step(1);
    edge_clear = 16'h0000;
    chk("lone_clear", edge_flags[3], 1'b0);
    pin_in[3] = 1'b0;
    step(12);
    chk("fall_data", data_in[3], 1'b0);
    chk("fall_flag", edge_flags[3], 1'b0);

    // Clear on the same cycle as a 0->1 commit
    pin_in[3] = 1'b1;
    step(9);
    edge_clear = 16'h0008;
    step(1);
    edge_clear = 16'h0000;
    chk("setclr_data", data_in[3], 1'b1);
    chk("setclr_flag", edge_flags[3], 1'b1);
    step(2);
    chk("setclr_hold", edge_flags[3], 1'b1);
    edge_clear = 16'h0008;
    step(1);
    edge_clear = 16'h0000;
    chk("later_clear", edge_flags[3], 1'b0);

    // Glitch shorter than deb_len
    pin_in[5] = 1'b1;
    step(6);
    pin_in[5] = 1'b0;
    step(15);
    chk("glitch_data", data_in[5], 1'b0);
    chk("glitch_flag", edge_flags[5], 1'b0);

    // Bypass, deb_len=0: toggling pin tracked with a 3-edge lag
    deb_len = 8'd0;
    step(2);
    for (int t = 0; t < 24; t++) v[t] = ((t / 4) % 2) == 1;
    for (int t = 0; t < 24; t++) begin
      pin_in[0] = v[t];
      step(1);
      if (t >= 2) chk($sformatf("bypass_%0d", t), data_in[0], v[t-2]);
    end
    pin_in[0] = 1'b0;
    step(4);

    // deb_len lowered mid-count
    deb_len   = 8'd200;
    pin_in[7] = 1'b1;
    step(52);
    chk("lower_early", data_in[7], 1'b0);
    deb_len = 8'd4;
    step(1);
    chk("lower_data", data_in[7], 1'b1);
    chk("lower_flag", edge_flags[7], 1'b1);

    // Asynchronous reset mid-count, no clock edge
    deb_len   = 8'd200;
    pin_in[9] = 1'b1;
    step(20);
    #2;
    theReset = 1'b0;
    #1;
    chk("arst_data_in", data_in, 16'h0000);
    chk("arst_edge_flags", edge_flags, 16'h0000);
    chk("arst_pin_out", pin_out, 16'h0000);
    step(2);
    theReset = 1'b1;
    // Counter and synchroniser restart from zero: commit needs full 2+200 edges.
    step(201);
    chk("arst_cnt_early", data_in[9], 1'b0);
    step(1);
    chk("arst_cnt_commit", data_in[9], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
